// File: rtl/dmem_pkg.sv
// Shared encodings and sizes for the DMEM block mover.
package dmem_pkg;

  localparam int unsigned DMEM_DEPTH = 32;
  localparam int unsigned ST_W       = 3;

  localparam logic [1:0] OP_COPY = 2'b00;
  localparam logic [1:0] OP_FILL = 2'b01;
  localparam logic [1:0] OP_SUM  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_CHECK = 3'd1;
  localparam logic [ST_W-1:0] ST_RD    = 3'd2;
  localparam logic [ST_W-1:0] ST_WR    = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/dmem_range_check.sv
// Command validation and COPY direction: one extra bit keeps base+len from wrapping.
module dmem_range_check
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_DEPTH,
  parameter int unsigned AW    = 8
) (
  input  logic [1:0]    op_i,
  input  logic [AW-1:0] src_i,
  input  logic [AW-1:0] dst_i,
  input  logic [AW-1:0] len_i,
  output logic          err_c_o,
  output logic          descend_c_o
);

  localparam int unsigned EW = AW + 1;

  logic [EW-1:0] src_end;
  logic [EW-1:0] dst_end;

  always_comb begin
    src_end = EW'(src_i) + EW'(len_i);
    dst_end = EW'(dst_i) + EW'(len_i);
    err_c_o = 1'b0;
    if (op_i == OP_RSVD) err_c_o = 1'b1;
    if ((op_i == OP_COPY || op_i == OP_SUM) && src_end > EW'(DEPTH)) err_c_o = 1'b1;
    if ((op_i == OP_COPY || op_i == OP_FILL) && dst_end > EW'(DEPTH)) err_c_o = 1'b1;
    // Destination overlapping the tail of the source must be walked backwards.
    descend_c_o = (dst_i > src_i) && (EW'(dst_i) < src_end);
  end

endmodule

// File: rtl/dmem_block_mover.sv
// Second DMEM master: runs one COPY / FILL / SUM command at a time.
module dmem_block_mover
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_DEPTH,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] len,
  input  logic [7:0]    fill_val,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [7:0]    sum_out,
  output logic [AW-1:0] memA,
  output logic          memRE,
  input  logic [7:0]    memRD,
  output logic [7:0]    memWD,
  output logic          memWE
);

  logic [ST_W-1:0] state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [AW-1:0]   src_q, src_d, dst_q, dst_d, len_q, len_d;
  logic [AW-1:0]   idx_q, idx_d, rem_q, rem_d, idx_step;
  logic [7:0]      fill_q, fill_d, data_q, data_d, sum_q, sum_d, wd_q, wd_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            descend_q, descend_d, err_q, err_d;
  logic            busy_q, busy_d, done_q, done_d, re_q, re_d, we_q, we_d;
  logic            chk_err, chk_desc, is_last;

  dmem_range_check #(.DEPTH(DEPTH), .AW(AW)) u_range_check (
    .op_i        (op_q),
    .src_i       (src_q),
    .dst_i       (dst_q),
    .len_i       (len_q),
    .err_c_o     (chk_err),
    .descend_c_o (chk_desc)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;   op_q <= '0;      src_q <= '0;   dst_q <= '0;
      len_q <= '0;          fill_q <= '0;    idx_q <= '0;   rem_q <= '0;
      descend_q <= 1'b0;    data_q <= '0;    sum_q <= '0;   err_q <= 1'b0;
      busy_q <= 1'b0;       done_q <= 1'b0;  re_q <= 1'b0;  we_q <= 1'b0;
      addr_q <= '0;         wd_q <= '0;
    end else begin
      state_q <= state_d;   op_q <= op_d;    src_q <= src_d; dst_q <= dst_d;
      len_q <= len_d;       fill_q <= fill_d; idx_q <= idx_d; rem_q <= rem_d;
      descend_q <= descend_d; data_q <= data_d; sum_q <= sum_d; err_q <= err_d;
      busy_q <= busy_d;     done_q <= done_d; re_q <= re_d;  we_q <= we_d;
      addr_q <= addr_d;     wd_q <= wd_d;
    end
  end

  // Next state; bus outputs are derived from the next state so they are registered.
  always_comb begin
    state_d = state_q;  op_d = op_q;      src_d = src_q;  dst_d = dst_q;
    len_d = len_q;      fill_d = fill_q;  idx_d = idx_q;  rem_d = rem_q;
    descend_d = descend_q; data_d = data_q; sum_d = sum_q; err_d = err_q;
    idx_step = descend_q ? idx_q - AW'(1) : idx_q + AW'(1);
    is_last  = (rem_q == AW'(1));

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d = op;  src_d = src_addr;  dst_d = dst_addr;  len_d = len;
          fill_d = fill_val;  err_d = 1'b0;  sum_d = '0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (chk_err) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (len_q == '0) begin
          state_d = ST_DONE;
        end else begin
          descend_d = chk_desc;
          idx_d     = chk_desc ? len_q - AW'(1) : '0;
          rem_d     = len_q;
          state_d   = (op_q == OP_FILL) ? ST_WR : ST_RD;
        end
      end
      ST_RD: begin
        if (op_q == OP_SUM) begin
          sum_d   = sum_q + memRD;
          idx_d   = idx_step;
          rem_d   = rem_q - AW'(1);
          state_d = is_last ? ST_DONE : ST_RD;
        end else begin
          data_d  = memRD;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        idx_d   = idx_step;
        rem_d   = rem_q - AW'(1);
        state_d = is_last ? ST_DONE : ((op_q == OP_COPY) ? ST_RD : ST_WR);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    re_d   = (state_d == ST_RD);
    we_d   = (state_d == ST_WR);
    addr_d = '0;
    wd_d   = '0;
    if (state_d == ST_RD) begin
      addr_d = src_q + idx_d;
    end else if (state_d == ST_WR) begin
      addr_d = dst_q + idx_d;
      wd_d   = (op_q == OP_FILL) ? fill_q : data_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign sum_out = sum_q;
  assign memA    = addr_q;
  assign memRE   = re_q;
  assign memWD   = wd_q;
  assign memWE   = we_q;

endmodule
